// File: rtl/tick_sequencer.sv
// Tick sequencer: prescaled tick generator with continuous and oneshot-burst modes.
// A sequence is armed from IDLE, runs with latched settings, and in oneshot mode
// ends with a one-cycle DONE state followed by a done pulse.
module tick_sequencer #(
  parameter int unsigned M = 8,
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         oneshot,
  input  logic [M-1:0] DIVISOR,
  input  logic [N-1:0] BURST,
  output logic         tick,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] tick_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e       state_q;
  logic [M-1:0] presc_q;
  logic [M-1:0] div_q;
  logic [N-1:0] burst_q;
  logic         oneshot_q;
  logic         tick_q;
  logic         done_q;
  logic [N-1:0] count_q;

  logic [N-1:0] count_inc;
  logic [M-1:0] presc_inc;
  logic         start_ok;

  // Incremented values and start qualification; a zero-length burst is not a sequence.
  always_comb begin
    count_inc = count_q + 1'b1;
    presc_inc = presc_q + 1'b1;
    start_ok  = start && !stop && !(oneshot && (BURST == '0));
  end

  // Sequencer FSM with registered tick/done pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      div_q     <= '0;
      burst_q   <= '0;
      oneshot_q <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q   <= StRun;
            div_q     <= DIVISOR;
            burst_q   <= BURST;
            oneshot_q <= oneshot;
            presc_q   <= '0;
            count_q   <= '0;
          end
        end
        StRun: begin
          if (stop) begin
            // Abort wins over a coincident tick; count is left as is.
            state_q <= StIdle;
          end else if (presc_q == div_q) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
            count_q <= count_inc;
            if (oneshot_q && (count_inc == burst_q)) begin
              state_q <= StDone;
            end
          end else begin
            presc_q <= presc_inc;
          end
        end
        StDone: begin
          // Final tick is visible during DONE; done follows one cycle later.
          state_q <= StIdle;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    tick       = tick_q;
    done       = done_q;
    busy       = (state_q != StIdle);
    tick_count = count_q;
  end

endmodule

// File: tb/tb_tick_sequencer.sv
// Self-checking bench for tick_sequencer: directed scenarios plus random traffic,
// compared every cycle against an elapsed-time reference model.
module tb_tick_sequencer;

  localparam int unsigned M = 8;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         oneshot = 1'b0;
  logic [M-1:0] DIVISOR = '0;
  logic [N-1:0] BURST = '0;
  logic         tick;
  logic         busy;
  logic         done;
  logic [N-1:0] tick_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: elapsed cycles since the accepting edge decide tick timing.
  bit m_run, m_fin, m_os, m_tick, m_done;
  int m_el, m_d, m_b, m_cnt;

  tick_sequencer #(
    .M(M),
    .N(N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .oneshot   (oneshot),
    .DIVISOR   (DIVISOR),
    .BURST     (BURST),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_step();
    if (reset) begin
      m_run = 0; m_fin = 0; m_os = 0; m_tick = 0; m_done = 0;
      m_el = 0; m_d = 0; m_b = 0; m_cnt = 0;
    end else begin
      m_tick = 0;
      m_done = 0;
      if (m_fin) begin
        m_fin  = 0;
        m_done = 1;
      end else if (m_run) begin
        if (stop) begin
          m_run = 0;
        end else begin
          m_el++;
          if (m_el % (m_d + 1) == 0) begin
            m_tick = 1;
            m_cnt  = (m_cnt + 1) % (1 << N);
            if (m_os && m_cnt == m_b) begin
              m_run = 0;
              m_fin = 1;
            end
          end
        end
      end else if (start && !stop && !(oneshot && BURST == 0)) begin
        m_run = 1; m_el = 0; m_d = int'(DIVISOR); m_b = int'(BURST);
        m_os = oneshot; m_cnt = 0;
      end
    end
  endtask

  // One clock: model follows the edge, DUT sampled 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, ".tick"}, int'(tick), int'(m_tick));
    check({tag, ".done"}, int'(done), int'(m_done));
    check({tag, ".busy"}, int'(busy), int'(m_run || m_fin));
    check({tag, ".count"}, int'(tick_count), m_cnt);
  endtask

  task automatic cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic set_in(input bit s, input bit p, input bit os, input int d, input int b);
    start = s; stop = p; oneshot = os; DIVISOR = M'(d); BURST = N'(b);
  endtask

  int ticks_seen;

  initial begin
    // Reset for two cycles.
    reset = 1'b1;
    cycle("reset");
    cycle("reset");
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;

    // Continuous, DIVISOR=3: tick every 4 cycles, count wraps 15->0.
    set_in(1, 0, 0, 3, 0);
    cycle("cont_start");
    check("cont_busy_after_start", int'(busy), 1);
    set_in(0, 0, 1, 7, 2);  // changes while running must be ignored
    cycles("cont_d3", 70);
    set_in(0, 1, 0, 0, 0);
    cycle("cont_stop");
    set_in(0, 0, 0, 0, 0);
    cycles("idle", 3);

    // Oneshot BURST=5, DIVISOR=1.
    set_in(1, 0, 1, 1, 5);
    cycle("os5_start");
    set_in(0, 0, 0, 0, 0);
    ticks_seen = 0;
    for (int i = 0; i < 14; i++) begin
      cycle("os5");
      if (tick) ticks_seen++;
    end
    check("os5_ticks", ticks_seen, 5);
    check("os5_final_count", int'(tick_count), 5);
    check("os5_idle", int'(busy), 0);

    // DIVISOR=0 continuous, then stop.
    set_in(1, 0, 0, 0, 0);
    cycle("d0_start");
    set_in(0, 0, 0, 0, 0);
    cycles("d0_run", 6);
    set_in(0, 1, 0, 0, 0);
    cycle("d0_stop");
    check("d0_stop_tick", int'(tick), 0);
    set_in(0, 0, 0, 0, 0);
    cycles("d0_after", 3);

    // Stop exactly when a tick is due (DIVISOR=2, due on third edge).
    set_in(1, 0, 1, 2, 9);
    cycle("due_start");
    set_in(0, 0, 0, 0, 0);
    cycles("due_wait", 2);
    set_in(0, 1, 0, 0, 0);
    cycle("due_stop");
    check("due_stop_tick", int'(tick), 0);
    check("due_stop_count", int'(tick_count), 0);
    set_in(0, 0, 0, 0, 0);
    cycles("due_after", 4);

    // Oneshot with BURST=0 is ignored; start+stop in IDLE stays idle.
    set_in(1, 0, 1, 1, 0);
    cycles("burst0", 3);
    check("burst0_busy", int'(busy), 0);
    set_in(1, 1, 0, 1, 3);
    cycles("start_stop", 3);
    check("start_stop_busy", int'(busy), 0);

    // Reset mid-burst after 3 ticks, then clean restart.
    set_in(1, 0, 1, 1, 8);
    cycle("rst_start");
    set_in(0, 0, 0, 0, 0);
    cycles("rst_run", 6);
    check("rst_pre_count", int'(tick_count), 3);
    reset = 1'b1;
    cycle("rst_mid");
    check("rst_mid_count", int'(tick_count), 0);
    reset = 1'b0;
    set_in(1, 0, 1, 2, 4);
    cycle("rst_restart");
    set_in(0, 0, 0, 0, 0);
    cycles("rst_rerun", 16);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 3) == 0);
      stop    = ($urandom_range(0, 29) == 0);
      oneshot = $urandom_range(0, 1) == 1;
      DIVISOR = M'($urandom_range(0, 5));
      BURST   = N'($urandom_range(0, 15));
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
